mc_control: RTL
===============

# mc_control

Multicycle main control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives every datapath enable and mux select, including the 2-bit AluOp consumed by the downstream ALU control decoder. Stalls on a single-bit memory ready handshake and traps unsupported opcodes.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction bits [31:26] from the instruction register
- MemReady  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, AluSrcA  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address
- AluSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- AluOp  out  2  00 add, 01 subtract, 10 decode funct field
- Illegal  out  1  unsupported opcode trap pulse
- State  out  4  current state, for debug

## Operation
- Single state register, 4 bits. Outputs are decoded combinationally from State. IRWrite and PCWrite in FETCH are additionally qualified by MemReady.
- While rst_n=0, State=FETCH and every output is forced to 0.
- Signals not listed for a state are 0.
- States, with asserted outputs and next state:
  - FETCH(0): MemRead, AluSrcB=01, AluOp=00, IRWrite=MemReady, PCWrite=MemReady. Next is DECODE if MemReady, else FETCH.
  - DECODE(1): AluSrcB=11, AluOp=00. Next is chosen by Opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → EXEC
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDI_EX (only with the macro; see Configuration)
    - any other opcode → TRAP
  - MEMADR(2): AluSrcA, AluSrcB=10, AluOp=00. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): MemRead, IorD. Next is MEMWB if MemReady, else MEMRD.
  - MEMWB(4): RegWrite, MemtoReg, RegDst=0. Next is FETCH.
  - MEMWR(5): MemWrite, IorD. Next is FETCH if MemReady, else MEMWR.
  - EXEC(6): AluSrcA, AluSrcB=00, AluOp=10. Next is RWB.
  - RWB(7): RegDst, RegWrite. Next is FETCH.
  - BRANCH(8): AluSrcA, AluSrcB=00, AluOp=01, PCWriteCond, PCSource=01. Next is FETCH.
  - JUMP(9): PCWrite, PCSource=10. Next is FETCH.
  - ADDI_EX(10): AluSrcA, AluSrcB=10, AluOp=00. Next is ADDI_WB.
  - ADDI_WB(11): RegWrite, RegDst=0, MemtoReg=0. Next is FETCH.
  - TRAP(12): Illegal. Next is FETCH. The PC was already incremented in FETCH, so execution resumes at the next instruction.
- Encodings 13–15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- Opcode is sampled only in DECODE and MEMADR; it is a don't-care in every other state.
- MemRead and MemWrite stay asserted for every stall cycle.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Cycles per instruction with MemReady held at 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal: 3
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- IRWrite and PCWrite pulse for exactly one cycle per fetch: the cycle in FETCH in which MemReady=1.
- Illegal is a one-cycle pulse.
- Reset mid-instruction:
  - Asynchronous: State goes to FETCH and outputs go to 0 without waiting for a clock edge.
  - Any partially completed memory access is abandoned.
  - The first fetch begins on the first rising edge after rst_n deasserts. FETCH outputs appear in the cycle after that release.

## Configuration
- MC_CONTROL_ADDI_EN defined: opcode 001000 decodes to ADDI_EX, then ADDI_WB.
- MC_CONTROL_ADDI_EN undefined:
  - opcode 001000 goes to TRAP;
  - states 10 and 11 are not generated and are treated as unreachable encodings.

## Test plan
- Reset asserted mid-MEMRD → State=0 and all outputs 0 immediately. After release with MemReady=1, IRWrite pulses in the first clocked cycle.
- lw (100011) with MemReady=1 → State sequence 0,1,2,3,4,0. MEMWB asserts RegWrite=1, MemtoReg=1.
- sw (101011) with MemReady=0 for 3 cycles in MEMWR → MemWrite high for 4 cycles, then State returns to 0. Total 7 cycles.
- R-type (000000) → AluOp=10 in EXEC, then RegDst=1 and RegWrite=1 in RWB. beq (000100) → AluOp=01, PCWriteCond=1, PCSource=01.
- Opcode 111111 → 0,1,12,0 with Illegal high only in state 12.
- Opcode 001000, macro defined → 0,1,10,11,0 with AluSrcB=10. Macro undefined → 0,1,12,0 with Illegal=1.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back.
// Define MC_CONTROL_ADDI_EN to add the addi path (ADDI_EX, ADDI_WB).
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       AluSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
`ifdef MC_CONTROL_ADDI_EN
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11,
`endif
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t state, state_next;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a, illegal;
    logic [1:0] pc_source, alu_src_b, alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        illegal       = 1'b0;
        pc_source     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = MemReady;
                pc_write   = MemReady;
                state_next = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYP:      state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI:      state_next = ADDI_EX;
`endif
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                state_next = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                state_next = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = RWB;
            end
            RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MC_CONTROL_ADDI_EN
            ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
            end
`endif
            // The PC already advanced in FETCH, so returning to FETCH skips the bad word.
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Gating with rst_n makes every control drop the instant reset asserts.
    assign PCWrite     = rst_n & pc_write;
    assign PCWriteCond = rst_n & pc_write_cond;
    assign IorD        = rst_n & i_or_d;
    assign MemRead     = rst_n & mem_read;
    assign MemWrite    = rst_n & mem_write;
    assign MemtoReg    = rst_n & mem_to_reg;
    assign IRWrite     = rst_n & ir_write;
    assign RegWrite    = rst_n & reg_write;
    assign RegDst      = rst_n & reg_dst;
    assign AluSrcA     = rst_n & alu_src_a;
    assign Illegal     = rst_n & illegal;
    assign PCSource    = {2{rst_n}} & pc_source;
    assign AluSrcB     = {2{rst_n}} & alu_src_b;
    assign AluOp       = {2{rst_n}} & alu_op;
    assign State       = state;

endmodule
